// File: rtl/sw_led_pkg.sv
// Shared constants for the switch/LED controller: LED mode encodings and
// default timing values for a 100 MHz board clock.
package sw_led_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_INVERT = 2'b11;

    // 10 ms debounce window and 2 Hz blink at 100 MHz.
    localparam int DEF_DEB_CYCLES = 1000000;
    localparam int DEF_BLINK_HALF = 25000000;
    localparam int DEF_PWM_BITS   = 4;

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchroniser, stability counter, debounced level
// and a one-cycle pulse on each accepted rising edge.
module sw_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_db,
    output logic o_edge
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_db;
    logic          r_edge;
    logic [CW-1:0] r_cnt;

    // Any cycle where the synchronised input agrees with the accepted level
    // restarts the count, so a change needs DEB_CYCLES consecutive disagreements.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_db   <= 1'b0;
            r_edge <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_sw;
            r_sync <= r_meta;
            r_edge <= 1'b0;
            if (r_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_cnt  <= '0;
                r_db   <= r_sync;
                r_edge <= r_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_db   = r_db;
    assign o_edge = r_edge;

endmodule

// File: rtl/sw_led_ctrl.sv
// N_CH switch-to-LED controller with debouncing and four global LED modes.
// Optional PWM brightness control is enabled by defining LED_PWM_EN.
module sw_led_ctrl
    import sw_led_pkg::*;
#(
    parameter int N_CH       = 16,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int BLINK_HALF = DEF_BLINK_HALF,
    parameter int PWM_BITS   = DEF_PWM_BITS
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_CH-1:0]     SW,
    input  logic [1:0]          MODE,
`ifdef LED_PWM_EN
    input  logic [PWM_BITS-1:0] BRIGHT,
`endif
    output logic [N_CH-1:0]     SW_DB,
    output logic [N_CH-1:0]     EDGE,
    output logic [N_CH-1:0]     LED
);

    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    logic [N_CH-1:0] w_db;
    logic [N_CH-1:0] w_edge;
    logic [N_CH-1:0] w_tog_eff;
    logic [N_CH-1:0] w_pre;
    logic [N_CH-1:0] w_gate;
    logic [N_CH-1:0] r_tog;
    logic [N_CH-1:0] r_led;
    logic [BW-1:0]   r_blink_cnt;
    logic            r_phase;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        sw_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_db (
            .i_clk (CLK),
            .i_rst (RST),
            .i_sw  (SW[g]),
            .o_db  (w_db[g]),
            .o_edge(w_edge[g])
        );
    end

    // Folding the pending edge in lets the LED follow one cycle after EDGE.
    assign w_tog_eff = r_tog ^ w_edge;

    always_comb begin
        w_pre = w_db;
        case (MODE)
            MODE_DIRECT: w_pre = w_db;
            MODE_TOGGLE: w_pre = w_tog_eff;
            MODE_BLINK:  w_pre = w_db & {N_CH{r_phase}};
            MODE_INVERT: w_pre = ~w_db;
            default:     w_pre = w_db;
        endcase
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] r_pwm_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    assign w_gate = {N_CH{r_pwm_cnt < BRIGHT}};
`else
    assign w_gate = {N_CH{1'b1}};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tog       <= '0;
            r_led       <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_tog <= w_tog_eff;
            r_led <= w_pre & w_gate;
            if (r_blink_cnt == BLINK_MAX) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign SW_DB = w_db;
    assign EDGE  = w_edge;
    assign LED   = r_led;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed bench for sw_led_ctrl with N_CH=4, DEB_CYCLES=4, BLINK_HALF=8.
// Define LED_PWM_EN to include the brightness scenario.
module tb_sw_led_ctrl;

    localparam int N_CH       = 4;
    localparam int DEB_CYCLES = 4;
    localparam int BLINK_HALF = 8;
    localparam int PWM_BITS   = 4;

    logic                CLK;
    logic                RST;
    logic [N_CH-1:0]     SW;
    logic [1:0]          MODE;
    logic [PWM_BITS-1:0] BRIGHT;
    logic [N_CH-1:0]     SW_DB;
    logic [N_CH-1:0]     EDGE;
    logic [N_CH-1:0]     LED;

    logic [N_CH-1:0] exp_q[$];
    int n_vec;
    int n_fail;

    sw_led_ctrl #(
        .N_CH      (N_CH),
        .DEB_CYCLES(DEB_CYCLES),
        .BLINK_HALF(BLINK_HALF),
        .PWM_BITS  (PWM_BITS)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .SW    (SW),
        .MODE  (MODE),
`ifdef LED_PWM_EN
        .BRIGHT(BRIGHT),
`endif
        .SW_DB (SW_DB),
        .EDGE  (EDGE),
        .LED   (LED)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [N_CH-1:0] sw_val, input logic [1:0] mode_val);
        RST  = 1'b1;
        SW   = sw_val;
        MODE = mode_val;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Scoreboard
    task automatic push_exp(input logic [N_CH-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk_pop(input string tag, input logic [N_CH-1:0] obs);
        logic [N_CH-1:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] e);
        push_exp(e);
        chk_pop(tag, obs);
    endtask

    function automatic logic [N_CH-1:0] blink_exp(input int k);
        // LED after edge k mirrors phase after edge k-1; SW_DB is full from edge 6.
        if (k >= 7 && (((k - 1) / BLINK_HALF) % 2) == 1) return 4'hF;
        return 4'h0;
    endfunction

    initial begin
        int n_edge;
        int n_on;
        int n_bad;
        logic [N_CH-1:0] tog_exp;

        n_vec  = 0;
        n_fail = 0;
        BRIGHT = '0;

        // 1. Reset with switches held high
        do_reset(4'hF, 2'b00);
        chk("rst_led", LED, 4'h0);
        chk("rst_swdb", SW_DB, 4'h0);
        chk("rst_edge", EDGE, 4'h0);
        repeat (5) tick();
        chk("rst_swdb_c5", SW_DB, 4'h0);
        tick();
        chk("rst_swdb_c6", SW_DB, 4'hF);
        chk("rst_edge_c6", EDGE, 4'hF);
        tick();
        chk("rst_edge_c7", EDGE, 4'h0);
        chk("rst_led_c7", LED, 4'hF);

        // 2. Bounce on SW[0]
        SW = 4'h0;
        repeat (10) tick();
        chk("bnc_settle", SW_DB, 4'h0);
        n_edge = 0;
        for (int i = 0; i < 10; i++) begin
            SW[0] = (i % 2 == 0);
            repeat (2) begin
                tick();
                if (EDGE[0]) n_edge++;
            end
        end
        SW[0] = 1'b1;
        repeat (5) begin
            tick();
            if (EDGE[0]) n_edge++;
        end
        chk("bnc_c5", SW_DB, 4'h0);
        tick();
        if (EDGE[0]) n_edge++;
        chk("bnc_c6", SW_DB, 4'h1);
        chk("bnc_edge_c6", EDGE, 4'h1);
        repeat (6) begin
            tick();
            if (EDGE[0]) n_edge++;
        end
        chk("bnc_edge_count", 4'(n_edge), 4'd1);

        // 3. DIRECT then INVERT
        SW   = 4'b0101;
        MODE = 2'b00;
        repeat (8) tick();
        chk("direct", LED, 4'b0101);
        MODE = 2'b11;
        tick();
        chk("invert", LED, 4'b1010);

        // 4. TOGGLE on SW[1]
        do_reset(4'h0, 2'b01);
        repeat (8) tick();
        chk("tog_init", LED, 4'h0);
        tog_exp = 4'h0;
        for (int p = 0; p < 3; p++) begin
            SW = 4'b0010;
            repeat (6) tick();
            chk("tog_edge", EDGE, 4'b0010);
            chk("tog_led_before", LED, tog_exp);
            tick();
            tog_exp = tog_exp ^ 4'b0010;
            chk("tog_led_after", LED, tog_exp);
            repeat (6) tick();
            SW = 4'b0000;
            repeat (10) tick();
            chk("tog_release", LED, tog_exp);
        end

        // 5. BLINK
        do_reset(4'h0, 2'b10);
        SW = 4'hF;
        for (int k = 1; k <= 40; k++) push_exp(blink_exp(k));
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk_pop("blink_on", LED);
        end
        SW = 4'h0;
        repeat (8) tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("blink_off", LED, 4'h0);
        end

`ifdef LED_PWM_EN
        // 6. PWM brightness
        BRIGHT = 4'd4;
        do_reset(4'hF, 2'b00);
        repeat (10) tick();
        n_on  = 0;
        n_bad = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (LED === 4'hF) n_on++;
            else if (LED !== 4'h0) n_bad++;
        end
        chk("pwm_on_count", 4'(n_on), 4'd8);
        chk("pwm_bad_count", 4'(n_bad), 4'd0);
        BRIGHT = 4'd0;
        repeat (2) tick();
        n_on = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (LED !== 4'h0) n_on++;
        end
        chk("pwm_zero", 4'(n_on), 4'd0);
`else
        n_on  = 0;
        n_bad = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_led_ctrl.md
Name: sw_led_ctrl

Overview:
- Parametrised successor to the single switch-to-LED buffer for the Nexys 4 DDR board.
- N_CH slide switches pass through a synchroniser and debouncer.
- LEDs are driven in one of four global modes: direct, toggle, blink, invert.
- Debounced levels and rising-edge pulses are exported so later designs can use clean switch inputs.

Parameters:
- N_CH, 16, number of switch/LED channels (1..16 on board).
- DEB_CYCLES, 1000000, stable cycles required before accepting a switch change (10 ms at 100 MHz); minimum 2.
- BLINK_HALF, 25000000, blink half-period in cycles (2 Hz at 100 MHz); minimum 2.
- PWM_BITS, 4, brightness resolution; used only with LED_PWM_EN.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RST  input  1  synchronous, active-high reset.
- SW  input  N_CH  raw asynchronous switch inputs.
- MODE  input  2  LED mode, synchronous to CLK: 00 DIRECT, 01 TOGGLE, 10 BLINK, 11 INVERT.
- SW_DB  output  N_CH  debounced switch levels.
- EDGE  output  N_CH  one-cycle pulse on each debounced rising edge.
- LED  output  N_CH  LED drive.

Behaviour:
- Reset (RST=1 at a CLK edge): clears sync flops, debounce counters, SW_DB, EDGE, toggle state, blink counter/phase, PWM counter, LED. All outputs read 0 the cycle after.
  - Reset mid-debounce discards partial counts.
- Synchroniser: 2 flops per channel; sync = second stage.
- Debounce, per channel, counter width $clog2(DEB_CYCLES):
  - If sync == SW_DB, counter clears.
  - Otherwise counter increments. When counter == DEB_CYCLES-1 and sync still differs, SW_DB <= sync and counter clears.
  - A single-cycle glitch restarts the count. A change is accepted only after DEB_CYCLES consecutive differing cycles.
  - Latency from a clean SW transition to SW_DB: 2 + DEB_CYCLES cycles.
- EDGE[i]: registered high in the same cycle SW_DB[i] goes 0->1, for exactly one cycle. Never on falling edges.
  - A switch held high through reset produces one EDGE pulse after release, since 0 is the post-reset state.
- Toggle state tog[i]: flips on EDGE[i]. Retained across MODE changes. Cleared only by reset.
- Blink prescaler: free-running counter 0..BLINK_HALF-1, shared by all channels. Phase flips on wrap; phase=0 after reset.
- Pre-LED value, combinational:
  - DIRECT: SW_DB.
  - TOGGLE: tog.
  - BLINK: SW_DB & {N_CH{phase}}.
  - INVERT: ~SW_DB.
- LED is registered from the pre-LED value: 1 cycle after SW_DB/tog/phase/MODE changes.
- MODE changes take effect on the LED one cycle later. No glitch logic is required.

Optional Feature:
- Macro LED_PWM_EN.
- Defined:
  - Adds port BRIGHT input PWM_BITS and a free-running PWM_BITS counter, reset to 0.
  - LED = registered (pre-LED & {N_CH{pwm_cnt < BRIGHT}}).
  - BRIGHT=0 keeps LEDs off. Maximum duty is (2^PWM_BITS-1)/2^PWM_BITS.
- Undefined: no BRIGHT port, no PWM counter; LED = registered pre-LED.

Decomposition:
- Shared package sw_led_pkg holds:
  - MODE encodings as localparams: MODE_DIRECT=2'b00, MODE_TOGGLE=2'b01, MODE_BLINK=2'b10, MODE_INVERT=2'b11.
  - Default DEB_CYCLES and BLINK_HALF for a 100 MHz clock.
- Sub-module sw_debounce: one channel with synchroniser, counter, SW_DB and EDGE. Instantiated N_CH times via generate.
- Mode mux, blink prescaler and PWM stay in the top.

Test Plan:
All scenarios use N_CH=4, DEB_CYCLES=4, BLINK_HALF=8.
1. Reset: RST=1 for 2 cycles with SW=4'hF -> LED, SW_DB, EDGE = 0. After release, SW_DB=4'hF at cycle 6, with EDGE=4'hF for one cycle.
2. Bounce: SW[0] toggles 0/1 every 2 cycles for 20 cycles, then holds 1 -> SW_DB[0] rises exactly 6 cycles after the final hold. Exactly one EDGE[0] pulse.
3. DIRECT/INVERT: MODE=00, SW=4'b0101 settled -> LED=0101. Switch MODE to 11 -> LED=1010 next cycle.
4. TOGGLE: MODE=01, three clean SW[1] press/release cycles -> LED[1] sequence 1,0,1, changing 1 cycle after each EDGE[1]. Release does not change LED.
5. BLINK: MODE=10, SW=4'hF settled -> LED alternates 4'h0/4'hF every 8 cycles. SW=0 -> LED=0 constantly.
6. LED_PWM_EN, PWM_BITS=4, BRIGHT=4, MODE=00, SW=4'hF -> LED high for 4 of every 16 cycles. BRIGHT=0 -> LED stays 0.
